rgb2y_ctrl: RTL and testbench

Frame-level sequencer and configuration controller for the rgb2y grayscale/gamma datapath. Tracks input video timing (dv/hs/vs) and produces pixel/line counters, line-end and frame-start strobes. Manages a double-buffered gamma LUT: software writes the inactive bank, and the active bank swaps only at a frame boundary. Optionally checks frame geometry against expected dimensions.

---
 rtl/rgb2y_ctrl_if.sv | 25 ++
 rtl/rgb2y_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rgb2y_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb2y_ctrl_if.sv
// Configuration bus between software and rgb2y_ctrl: LUT writes, bank commit and busy.
// The master drives the requests; rgb2y_ctrl (slave) reports busy while a commit is pending.
interface rgb2y_ctrl_if;
    logic       cfg_we_i;
    logic [7:0] cfg_addr_i;
    logic [7:0] cfg_data_i;
    logic       cfg_commit_i;
    logic       cfg_busy_o;

    modport master (
        output cfg_we_i,
        output cfg_addr_i,
        output cfg_data_i,
        output cfg_commit_i,
        input  cfg_busy_o
    );

    modport slave (
        input  cfg_we_i,
        input  cfg_addr_i,
        input  cfg_data_i,
        input  cfg_commit_i,
        output cfg_busy_o
    );
endinterface

// File: rtl/rgb2y_ctrl.sv
// Frame sequencer and double-buffered gamma LUT controller for the rgb2y datapath.
// Define RGB2Y_CTRL_ERR_EN to enable frame geometry checking (frame_err_o).
module rgb2y_ctrl #(
    parameter int PX_W = 12,
    parameter int LN_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    rgb2y_ctrl_if.slave     cfg,
    input  logic            dv_i,
    input  logic            hs_i,
    input  logic            vs_i,
    input  logic [PX_W-1:0] exp_width_i,
    input  logic [LN_W-1:0] exp_height_i,
    input  logic            err_clr_i,
    output logic            lut_we_o,
    output logic            lut_bank_o,
    output logic [7:0]      lut_addr_o,
    output logic [7:0]      lut_data_o,
    output logic            active_bank_o,
    output logic [PX_W-1:0] px_cnt_o,
    output logic [LN_W-1:0] line_cnt_o,
    output logic            line_end_o,
    output logic            frame_start_o,
    output logic            frame_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } cfg_state_t;

    localparam logic [PX_W-1:0] PX_MAX = {PX_W{1'b1}};
    localparam logic [PX_W-1:0] PX_ONE = {{(PX_W-1){1'b0}}, 1'b1};
    localparam logic [LN_W-1:0] LN_MAX = {LN_W{1'b1}};
    localparam logic [LN_W-1:0] LN_ONE = {{(LN_W-1){1'b0}}, 1'b1};

    cfg_state_t      state_r;
    logic            dv_q_r;
    logic            vs_q_r;
    logic [PX_W-1:0] px_cnt_r;
    logic [LN_W-1:0] line_cnt_r;
    logic [LN_W-1:0] line_next_s;
    logic            line_end_r;
    logic            frame_start_r;
    logic            busy_r;
    logic            active_bank_r;
    logic            lut_we_r;
    logic            lut_bank_r;
    logic [7:0]      lut_addr_r;
    logic [7:0]      lut_data_r;
    logic            dv_fall_s;
    logic            vs_rise_s;

    assign dv_fall_s = dv_q_r & ~dv_i;
    assign vs_rise_s = vs_i & ~vs_q_r;

    // Line count including a line end landing in this cycle (used for the height check too).
    always_comb begin
        line_next_s = line_cnt_r;
        if (dv_fall_s && (line_cnt_r != LN_MAX)) begin
            line_next_s = line_cnt_r + LN_ONE;
        end else begin
            line_next_s = line_cnt_r;
        end
    end

    // Edge detection, pixel/line counters and timing strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q_r        <= 1'b0;
            vs_q_r        <= 1'b0;
            px_cnt_r      <= {PX_W{1'b0}};
            line_cnt_r    <= {LN_W{1'b0}};
            line_end_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            dv_q_r        <= dv_i;
            vs_q_r        <= vs_i;
            line_end_r    <= dv_fall_s;
            frame_start_r <= vs_rise_s;
            if (dv_fall_s || vs_rise_s) begin
                px_cnt_r <= {PX_W{1'b0}};
            end else if (dv_i && (px_cnt_r != PX_MAX)) begin
                px_cnt_r <= px_cnt_r + PX_ONE;
            end else begin
                px_cnt_r <= px_cnt_r;
            end
            if (vs_rise_s) begin
                line_cnt_r <= {LN_W{1'b0}};
            end else begin
                line_cnt_r <= line_next_s;
            end
        end
    end

    // Config FSM: busy stays high through the swap cycle and drops one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            active_bank_r <= 1'b0;
            lut_we_r      <= 1'b0;
            lut_bank_r    <= 1'b0;
            lut_addr_r    <= 8'h00;
            lut_data_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    lut_we_r <= cfg.cfg_we_i;
                    if (cfg.cfg_we_i) begin
                        lut_bank_r <= ~active_bank_r;
                        lut_addr_r <= cfg.cfg_addr_i;
                        lut_data_r <= cfg.cfg_data_i;
                    end else begin
                        lut_bank_r <= lut_bank_r;
                    end
                    if (cfg.cfg_commit_i) begin
                        state_r <= ST_PENDING;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    lut_we_r <= 1'b0;
                    busy_r   <= 1'b1;
                    if (vs_rise_s) begin
                        active_bank_r <= ~active_bank_r;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_PENDING;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    lut_we_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RGB2Y_CTRL_ERR_EN
    logic seen_vs_r;
    logic frame_err_r;
    logic err_set_s;

    // The first vs rise after reset closes a partial frame, so its height is not judged.
    assign err_set_s = (dv_fall_s && (px_cnt_r != exp_width_i)) ||
                       (vs_rise_s && seen_vs_r && (line_next_s != exp_height_i));

    // Sticky geometry error; a new failure beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_vs_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (vs_rise_s) begin
                seen_vs_r <= 1'b1;
            end else begin
                seen_vs_r <= seen_vs_r;
            end
            if (err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign frame_err_o = frame_err_r;

    logic unused_s;
    assign unused_s = hs_i;
`else
    assign frame_err_o = 1'b0;

    logic unused_s;
    assign unused_s = ^{hs_i, err_clr_i, exp_width_i, exp_height_i};
`endif

    assign cfg.cfg_busy_o = busy_r;
    assign lut_we_o       = lut_we_r;
    assign lut_bank_o     = lut_bank_r;
    assign lut_addr_o     = lut_addr_r;
    assign lut_data_o     = lut_data_r;
    assign active_bank_o  = active_bank_r;
    assign px_cnt_o       = px_cnt_r;
    assign line_cnt_o     = line_cnt_r;
    assign line_end_o     = line_end_r;
    assign frame_start_o  = frame_start_r;

endmodule

// File: tb/tb_rgb2y_ctrl.sv
// Directed self-checking bench for rgb2y_ctrl: counters, strobes, LUT banking, errors, reset.
module tb_rgb2y_ctrl;
    localparam int PX_W = 12;
    localparam int LN_W = 11;
`ifdef RGB2Y_CTRL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            dv_i, hs_i, vs_i, err_clr_i;
    logic [PX_W-1:0] exp_width_i;
    logic [LN_W-1:0] exp_height_i;
    logic            lut_we_o, lut_bank_o, active_bank_o;
    logic [7:0]      lut_addr_o, lut_data_o;
    logic [PX_W-1:0] px_cnt_o;
    logic [LN_W-1:0] line_cnt_o;
    logic            line_end_o, frame_start_o, frame_err_o;
    int              checks = 0;
    int              errors = 0;

    rgb2y_ctrl_if cfg ();

    rgb2y_ctrl #(.PX_W(PX_W), .LN_W(LN_W)) dut (
        .clk(clk), .rst(rst), .cfg(cfg),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .exp_width_i(exp_width_i), .exp_height_i(exp_height_i), .err_clr_i(err_clr_i),
        .lut_we_o(lut_we_o), .lut_bank_o(lut_bank_o), .lut_addr_o(lut_addr_o), .lut_data_o(lut_data_o),
        .active_bank_o(active_bank_o), .px_cnt_o(px_cnt_o), .line_cnt_o(line_cnt_o),
        .line_end_o(line_end_o), .frame_start_o(frame_start_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int n);
        dv_i = 1'b1;
        repeat (n) step();
        check_eq("px_cnt_line", 32'(px_cnt_o), 32'(n > 4095 ? 4095 : n));
        dv_i = 1'b0;
        step();
        check_eq("line_end_hi", 32'(line_end_o), 32'd1);
        check_eq("px_cnt_clr", 32'(px_cnt_o), 32'd0);
        step();
        check_eq("line_end_lo", 32'(line_end_o), 32'd0);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        step();
        check_eq("frame_start_hi", 32'(frame_start_o), 32'd1);
        check_eq("line_cnt_frame", 32'(line_cnt_o), 32'd0);
        vs_i = 1'b0;
        step();
        check_eq("frame_start_lo", 32'(frame_start_o), 32'd0);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check_eq("err_clr", 32'(frame_err_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_px"}, 32'(px_cnt_o), 32'd0);
        check_eq({tag, "_line"}, 32'(line_cnt_o), 32'd0);
        check_eq({tag, "_bank"}, 32'(active_bank_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(cfg.cfg_busy_o), 32'd0);
        check_eq({tag, "_lutwe"}, 32'(lut_we_o), 32'd0);
        check_eq({tag, "_strobes"}, 32'({line_end_o, frame_start_o}), 32'd0);
        check_eq({tag, "_err"}, 32'(frame_err_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; err_clr_i = 1'b0;
        exp_width_i = 12'd640; exp_height_i = 11'd3;
        cfg.cfg_we_i = 1'b0; cfg.cfg_addr_i = 8'h00; cfg.cfg_data_i = 8'h00; cfg.cfg_commit_i = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // First frame start after reset: never height-checked.
        vs_pulse();
        check_eq("first_vs_err", 32'(frame_err_o), 32'd0);

        for (int i = 0; i < 3; i++) run_line(640);
        check_eq("line_cnt_3", 32'(line_cnt_o), 32'd3);
        check_eq("err_good_lines", 32'(frame_err_o), 32'd0);
        vs_pulse();
        check_eq("err_good_height", 32'(frame_err_o), 32'd0);

        // Short line: error one cycle after the dv fall, cleared by err_clr.
        dv_i = 1'b1;
        repeat (639) step();
        dv_i = 1'b0;
        step();
        check_eq("short_line_end", 32'(line_end_o), 32'd1);
        check_eq("short_line_err", 32'(frame_err_o), 32'(ERR));
        step();
        clear_err();

        // Height 1 != 3 at vs rise with a simultaneous clear: set wins.
        vs_i = 1'b1; err_clr_i = 1'b1;
        step();
        vs_i = 1'b0; err_clr_i = 1'b0;
        check_eq("height_err_set_wins", 32'(frame_err_o), 32'(ERR));
        step();
        clear_err();
        exp_height_i = 11'd0;

        // LUT write into inactive bank.
        cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = 8'h10; cfg.cfg_data_i = 8'hF3;
        step();
        cfg.cfg_we_i = 1'b0;
        check_eq("lut_we", 32'(lut_we_o), 32'd1);
        check_eq("lut_addr", 32'(lut_addr_o), 32'h10);
        check_eq("lut_data", 32'(lut_data_o), 32'hF3);
        check_eq("lut_bank", 32'(lut_bank_o), 32'd1);
        step();
        check_eq("lut_we_pulse", 32'(lut_we_o), 32'd0);

        // Commit mid-frame; writes ignored while pending; swap at next vs rise.
        cfg.cfg_commit_i = 1'b1;
        step();
        cfg.cfg_commit_i = 1'b0;
        check_eq("busy_after_commit", 32'(cfg.cfg_busy_o), 32'd1);
        cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = 8'h22; cfg.cfg_data_i = 8'h55;
        step();
        cfg.cfg_we_i = 1'b0;
        check_eq("write_ignored", 32'(lut_we_o), 32'd0);
        check_eq("bank_before_swap", 32'(active_bank_o), 32'd0);
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
        check_eq("swap_frame_start", 32'(frame_start_o), 32'd1);
        check_eq("swap_bank", 32'(active_bank_o), 32'd1);
        check_eq("swap_busy_hold", 32'(cfg.cfg_busy_o), 32'd1);
        step();
        check_eq("swap_busy_clear", 32'(cfg.cfg_busy_o), 32'd0);

        // Commit coincident with vs rise: no swap now, swap at the following vs rise.
        vs_i = 1'b1; cfg.cfg_commit_i = 1'b1;
        step();
        vs_i = 1'b0; cfg.cfg_commit_i = 1'b0;
        check_eq("coinc_no_swap", 32'(active_bank_o), 32'd1);
        check_eq("coinc_busy", 32'(cfg.cfg_busy_o), 32'd1);
        step();
        vs_i = 1'b1;
        step();
        vs_i = 1'b0;
        check_eq("coinc_swap_next", 32'(active_bank_o), 32'd0);
        step();
        check_eq("coinc_busy_clear", 32'(cfg.cfg_busy_o), 32'd0);
        cfg.cfg_we_i = 1'b1; cfg.cfg_addr_i = 8'h01; cfg.cfg_data_i = 8'h02;
        step();
        cfg.cfg_we_i = 1'b0;
        check_eq("lut_bank_after_swap", 32'(lut_bank_o), 32'd1);

        // Pixel counter saturation.
        run_line(4100);
        check_eq("sat_line_err", 32'(frame_err_o), 32'(ERR));
        clear_err();
        exp_height_i = 11'd1;
        vs_pulse();
        check_eq("height_one_ok", 32'(frame_err_o), 32'd0);

        // Reset while pending with five lines counted.
        exp_width_i = 12'd4;
        for (int i = 0; i < 5; i++) run_line(4);
        check_eq("line_cnt_5", 32'(line_cnt_o), 32'd5);
        check_eq("small_lines_err", 32'(frame_err_o), 32'd0);
        cfg.cfg_commit_i = 1'b1;
        step();
        cfg.cfg_commit_i = 1'b0;
        check_eq("pending_busy", 32'(cfg.cfg_busy_o), 32'd1);
        rst = 1'b1;
        #2;
        check_all_zero("midrst");
        step();
        rst = 1'b0;
        step();
        exp_height_i = 11'd7;
        vs_pulse();
        check_eq("post_rst_first_vs_err", 32'(frame_err_o), 32'd0);
        check_eq("post_rst_bank", 32'(active_bank_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
